// File: rtl/regfile_mp_sb_if.sv
// Register-file bundle: the two read ports, the two write ports, the issue port
// and the scoreboard status, grouped for the ID stage.
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              pend1;
    logic              pend2;
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd1;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              busy_any;

    modport master (
        output ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_addr,
        input  rd1, rd2, pend1, pend2, busy_any
    );

    modport slave (
        input  ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_addr,
        output rd1, rd2, pend1, pend2, busy_any
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Two-read / two-write register file with write-first bypass and a per-register
// pending scoreboard tracking outstanding long-latency (port 1) results.
module regfile_mp_sb #(
    parameter int                 DATA_W  = 32,
    parameter int                 ADDR_W  = 5,
    parameter int                 SP_IDX  = 29,
    parameter logic [DATA_W-1:0]  SP_INIT = 32'h200,
    parameter int                 BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_mp_sb_if.slave        bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  sb;

    assign regs[0] = '0;
    assign sb[0]   = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            localparam logic [DATA_W-1:0] RST_VAL = (gi == SP_IDX) ? SP_INIT : '0;

            logic [DATA_W-1:0] data_reg;
            logic              pend_reg;

            // Port 0 is tested first so it wins a same-address collision.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg <= RST_VAL;
                end else if (bus.we0 && bus.wa0 == IDX) begin
                    data_reg <= bus.wd0;
                end else if (bus.we1 && bus.wa1 == IDX) begin
                    data_reg <= bus.wd1;
                end
            end

            // A new issue outranks the completing write: it names a new producer.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pend_reg <= 1'b0;
                end else if (bus.iss_en && bus.iss_addr == IDX) begin
                    pend_reg <= 1'b1;
                end else if (bus.we1 && bus.wa1 == IDX) begin
                    pend_reg <= 1'b0;
                end
            end

            assign regs[gi] = data_reg;
            assign sb[gi]   = pend_reg;
        end
    endgenerate

    logic [ADDR_W-1:0] ra   [2];
    logic [DATA_W-1:0] rd   [2];
    logic              pend [2];

    assign ra[0]     = bus.ra1;
    assign ra[1]     = bus.ra2;
    assign bus.rd1   = rd[0];
    assign bus.rd2   = rd[1];
    assign bus.pend1 = pend[0];
    assign bus.pend2 = pend[1];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            if (BYPASS != 0) begin : g_byp
                always_comb begin
                    rd[gi] = regs[ra[gi]];
                    if (ra[gi] == '0) begin
                        rd[gi] = '0;
                    end else if (bus.we0 && bus.wa0 == ra[gi]) begin
                        rd[gi] = bus.wd0;
                    end else if (bus.we1 && bus.wa1 == ra[gi]) begin
                        rd[gi] = bus.wd1;
                    end
                end
                // The clearing write is forwarded, so it must not also stall.
                assign pend[gi] = sb[ra[gi]] && !(bus.we1 && bus.wa1 == ra[gi]);
            end else begin : g_nobyp
                assign rd[gi]   = regs[ra[gi]];
                assign pend[gi] = sb[ra[gi]];
            end
        end
    endgenerate

    assign bus.busy_any = |sb;
endmodule
